// File: rtl/ev_frame_pingpong.sv
// Ping-pong event-frame memory. Events set polarity bits in the active bank
// while the other bank streams out in raster order and is cleared behind the read.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_INIT   | power-up sweep, zeroing address ptr in both banks
// S_IDLE   | collecting events, waiting for rd_start
// S_STREAM | fetching the finished bank into the output register
module ev_frame_pingpong #(
    parameter int DEPTH  = 76800,
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ev_valid,
    output logic              ev_ready,
    input  logic [ADDR_W-1:0] ev_addr,
    input  logic              ev_pol,
    input  logic              rd_start,
    output logic              rd_busy,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [PIX_W-1:0]  rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_last,
    output logic              bank_sel,
    output logic              init_done,
    output logic [CNT_W-1:0]  frame_ev_cnt,
    output logic [CNT_W-1:0]  ev_drop_cnt
);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_STREAM} state_t;

    localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_P  = (ADDR_W+1)'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W:0]   ptr;
    logic [ADDR_W-1:0] ptr_a;
    logic [CNT_W-1:0]  ev_cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              ev_acc;
    logic              ev_in_range;
    logic              ev_we;
    logic              fetch;
    logic              init_clr;

    logic [PIX_W-1:0] bank0 [DEPTH];
    logic [PIX_W-1:0] bank1 [DEPTH];

    assign ev_ready    = init_done;
    assign ptr_a       = ptr[ADDR_W-1:0];
    assign ev_acc      = ev_valid & init_done;
    assign ev_in_range = ({1'b0, ev_addr} < DEPTH_P);
    assign ev_we       = ev_acc & ev_in_range;
    assign init_clr    = (state == S_INIT);
    assign fetch       = (state == S_STREAM) && (ptr < DEPTH_P) && (!rd_valid || rd_ready);

    always_comb begin
        cnt_next = ev_cnt;
        if (ev_we && (ev_cnt != '1))
            cnt_next = ev_cnt + 1'b1;
    end

    // Port E targets bank[bank_sel], port R targets the other one, so the two never collide.
    always_ff @(posedge clk) begin
        if (init_clr) begin
            bank0[ptr_a] <= '0;
            bank1[ptr_a] <= '0;
        end else begin
            if (ev_we) begin
                if (bank_sel)
                    bank1[ev_addr][ev_pol] <= 1'b1;
                else
                    bank0[ev_addr][ev_pol] <= 1'b1;
            end
            if (fetch) begin
                if (bank_sel)
                    bank0[ptr_a] <= '0;
                else
                    bank1[ptr_a] <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_INIT;
            ptr          <= '0;
            bank_sel     <= 1'b0;
            init_done    <= 1'b0;
            rd_busy      <= 1'b0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            rd_addr      <= '0;
            rd_last      <= 1'b0;
            ev_cnt       <= '0;
            frame_ev_cnt <= '0;
            ev_drop_cnt  <= '0;
        end else begin
            ev_cnt <= cnt_next;
            if (ev_acc && !ev_in_range && (ev_drop_cnt != '1))
                ev_drop_cnt <= ev_drop_cnt + 1'b1;

            case (state)
                S_INIT: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST_P) begin
                        ptr       <= '0;
                        init_done <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (rd_start) begin
                        bank_sel     <= ~bank_sel;
                        frame_ev_cnt <= cnt_next;
                        ev_cnt       <= '0;
                        ptr          <= '0;
                        rd_busy      <= 1'b1;
                        state        <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (rd_valid && rd_ready) begin
                        rd_valid <= 1'b0;
                        if (rd_last) begin
                            rd_last <= 1'b0;
                            rd_busy <= 1'b0;
                            state   <= S_IDLE;
                        end
                    end
                    // Read-first: the zero-write above leaves this read with the old pixel.
                    if (fetch) begin
                        rd_valid <= 1'b1;
                        rd_data  <= bank_sel ? bank0[ptr_a] : bank1[ptr_a];
                        rd_addr  <= ptr_a;
                        rd_last  <= (ptr == LAST_P);
                        ptr      <= ptr + 1'b1;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ev_frame_pingpong.sv
// Scoreboard bench for ev_frame_pingpong: a per-frame pixel-set model predicts each
// streamed frame at the swap; a negedge monitor pops and compares accepted beats.
module tb_ev_frame_pingpong;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 5;
    localparam int PIX_W  = 2;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ev_valid = 1'b0;
    logic              ev_ready;
    logic [ADDR_W-1:0] ev_addr = '0;
    logic              ev_pol = 1'b0;
    logic              rd_start = 1'b0;
    logic              rd_busy;
    logic              rd_valid;
    logic              rd_ready = 1'b1;
    logic [PIX_W-1:0]  rd_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_last;
    logic              bank_sel;
    logic              init_done;
    logic [CNT_W-1:0]  frame_ev_cnt;
    logic [CNT_W-1:0]  ev_drop_cnt;

    ev_frame_pingpong #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .PIX_W(PIX_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_addr(ev_addr), .ev_pol(ev_pol),
        .rd_start(rd_start), .rd_busy(rd_busy),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_addr(rd_addr), .rd_last(rd_last),
        .bank_sel(bank_sel), .init_done(init_done),
        .frame_ev_cnt(frame_ev_cnt), .ev_drop_cnt(ev_drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        int last;
        int fcnt;
    } beat_t;

    beat_t q[$];
    int checks = 0;
    int failures = 0;

    // Reference model: pixel sets per bank, counters and a few flags.
    bit [PIX_W-1:0] mb [2][DEPTH];
    int m_sel, m_cnt, m_drop, m_frame, m_busy, m_init, m_edges;
    bit pending_done = 0;
    bit rand_rdy = 0;

    bit stall_hold = 0;
    int hold_addr, hold_data, hold_last;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int j = 0; j < DEPTH; j++)
                mb[b][j] = '0;
        m_sel = 0; m_cnt = 0; m_drop = 0; m_frame = 0;
        m_busy = 0; m_init = 0; m_edges = 0;
        pending_done = 0;
        q.delete();
    endtask

    task automatic check_reset_vals();
        check("rst ev_ready", ev_ready, 0);
        check("rst rd_busy", rd_busy, 0);
        check("rst rd_valid", rd_valid, 0);
        check("rst rd_last", rd_last, 0);
        check("rst init_done", init_done, 0);
        check("rst bank_sel", bank_sel, 0);
        check("rst rd_data", rd_data, 0);
        check("rst rd_addr", rd_addr, 0);
        check("rst frame_ev_cnt", frame_ev_cnt, 0);
        check("rst ev_drop_cnt", ev_drop_cnt, 0);
    endtask

    // One clock cycle of stimulus; the model applies the cycle's effects at the edge.
    task automatic cyc(input bit v, input int a, input bit p, input bit s);
        ev_valid = v;
        ev_addr  = a[ADDR_W-1:0];
        ev_pol   = p;
        rd_start = s;
        rd_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk);
        if (rst_n) begin
            if (m_init != 0) begin
                if (v) begin
                    if (a < DEPTH) begin
                        mb[m_sel][a][p] = 1'b1;
                        if (m_cnt < CMAX) m_cnt++;
                    end else if (m_drop < CMAX) begin
                        m_drop++;
                    end
                end
                if (s && m_busy == 0) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        q.push_back('{j, int'(mb[m_sel][j]), (j == DEPTH - 1) ? 1 : 0, m_cnt});
                        mb[m_sel][j] = '0;
                    end
                    m_frame = m_cnt;
                    m_cnt   = 0;
                    m_sel   = 1 - m_sel;
                    m_busy  = 1;
                end
            end else begin
                m_edges++;
                if (m_edges == DEPTH) m_init = 1;
            end
            if (pending_done) begin
                m_busy = 0;
                pending_done = 0;
            end
        end
        #1;
        ev_valid = 1'b0;
        rd_start = 1'b0;
        if (rst_n) begin
            check("rd_busy", rd_busy, m_busy);
            check("bank_sel", bank_sel, m_sel);
            check("ev_ready", ev_ready, m_init);
            check("init_done", init_done, m_init);
            check("ev_drop_cnt", ev_drop_cnt, m_drop);
            check("frame_ev_cnt", frame_ev_cnt, m_frame);
        end
    endtask

    task automatic rand_cyc(input bit with_ev);
        cyc(with_ev ? 1'($urandom_range(0, 1)) : 1'b0, $urandom_range(0, 19),
            1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic do_init();
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, i, 1'b1, (i % 5 == 2) || (i == DEPTH - 1));
            if (i == DEPTH - 2) begin
                check("init_done early", init_done, 0);
                check("rd_busy during init", rd_busy, 0);
            end
        end
        check("init_done at DEPTH", init_done, 1);
        check("ev_ready at DEPTH", ev_ready, 1);
        check("rd_busy after init", rd_busy, 0);
    endtask

    task automatic wait_idle(input bit with_ev, input int bound);
        int n = 0;
        while (rd_busy && n < bound) begin
            rand_cyc(with_ev);
            n++;
        end
        if (rd_busy) check("stream timeout", n, bound + 1);
        check("queue drained", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_hold = 0;
        end else begin
            if (stall_hold) begin
                check("stall rd_valid", rd_valid, 1);
                check("stall rd_addr", rd_addr, hold_addr);
                check("stall rd_data", rd_data, hold_data);
                check("stall rd_last", rd_last, hold_last);
            end
            stall_hold = 0;
            if (rd_valid && rd_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected beat: addr %0d data %0d with no frame pending", rd_addr, rd_data);
                end else begin
                    beat_t b;
                    b = q.pop_front();
                    check("beat addr", rd_addr, b.addr);
                    check("beat data", rd_data, b.data);
                    check("beat last", rd_last, b.last);
                    check("beat frame_ev_cnt", frame_ev_cnt, b.fcnt);
                    if (b.last != 0) pending_done = 1;
                end
            end else if (rd_valid) begin
                stall_hold = 1;
                hold_addr = int'(rd_addr);
                hold_data = int'(rd_data);
                hold_last = int'(rd_last);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        rst_n = 1'b1;
        do_init();

        // Basic frame and throughput
        cyc(1'b1, 3, 1'b1, 1'b0);
        cyc(1'b1, 3, 1'b0, 1'b0);
        cyc(1'b1, 7, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b1);
        check("swap frame_ev_cnt", frame_ev_cnt, 3);
        check("swap rd_busy", rd_busy, 1);
        n = 0;
        while (rd_busy && n < 100) begin
            cyc(1'b0, 0, 1'b0, 1'b0);
            n++;
        end
        check("frame cycles", n, DEPTH + 1);
        check("queue drained", q.size(), 0);

        // Clear-behind: two empty frames, the second revisits the first bank
        cyc(1'b0, 0, 1'b0, 1'b1);
        wait_idle(1'b0, 100);
        cyc(1'b0, 0, 1'b0, 1'b1);
        wait_idle(1'b0, 100);

        // Swap boundary
        cyc(1'b1, 5, 1'b1, 1'b1);
        cyc(1'b1, 6, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b1);
        wait_idle(1'b0, 100);
        cyc(1'b0, 0, 1'b0, 1'b1);
        wait_idle(1'b0, 100);

        // Backpressure with random events, several rounds
        rand_rdy = 1;
        for (int r = 0; r < 4; r++) begin
            repeat (10) rand_cyc(1'b1);
            cyc(1'b1, $urandom_range(0, 15), 1'($urandom_range(0, 1)), 1'b1);
            cyc(1'b0, 0, 1'b0, 1'b1);
            wait_idle(1'b1, 400);
        end
        rand_rdy = 0;

        // Out-of-range events
        n = int'(ev_drop_cnt);
        cyc(1'b1, 20, 1'b1, 1'b0);
        check("drop increment", ev_drop_cnt, (n < CMAX) ? n + 1 : CMAX);
        cyc(1'b1, 31, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b1);
        wait_idle(1'b0, 100);

        // Event counter saturation
        for (int i = 0; i < 20; i++)
            cyc(1'b1, i % DEPTH, 1'($urandom_range(0, 1)), 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b1);
        check("saturated frame_ev_cnt", frame_ev_cnt, CMAX);
        wait_idle(1'b0, 100);

        // Reset in the middle of a stream
        cyc(1'b1, 9, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b1);
        repeat (5) cyc(1'b0, 0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_init();
        cyc(1'b1, 15, 1'b0, 1'b0);
        cyc(1'b1, 0, 1'b1, 1'b1);
        wait_idle(1'b0, 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ev_frame_pingpong.md
# ev_frame_pingpong

Parametrised ping-pong event-frame memory for the event-to-QVGA path. Events are written into the active bank as per-pixel polarity bits using masked writes. The other bank is streamed out in raster order with a valid/ready handshake and cleared behind the read. One readout request swaps the banks atomically. After reset, both banks are swept to zero before any event is accepted.

## Interface
Parameters:
- DEPTH, 76800: pixels per frame (320x240); valid addresses are 0..DEPTH-1.
- ADDR_W, 17: pixel address width; must satisfy 2^ADDR_W >= DEPTH.
- PIX_W, 2: bits per pixel; bit 0 = OFF event seen, bit 1 = ON event seen.
- CNT_W, 16: width of the event and drop counters.

Ports:
- clk  in  1  single clock; all state is rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ev_valid  in  1  event present.
- ev_ready  out  1  event accepted when ev_valid & ev_ready.
- ev_addr  in  ADDR_W  pixel address.
- ev_pol  in  1  polarity; 1 sets pixel bit 1, 0 sets pixel bit 0.
- rd_start  in  1  single-cycle request to swap banks and stream the finished frame.
- rd_busy  out  1  high from the swap until the last beat is accepted.
- rd_valid  out  1  output beat valid.
- rd_ready  in  1  sink ready.
- rd_data  out  PIX_W  pixel bits.
- rd_addr  out  ADDR_W  address of rd_data.
- rd_last  out  1  high on the beat with rd_addr = DEPTH-1.
- bank_sel  out  1  bank currently receiving events.
- init_done  out  1  high once the power-up clear has finished.
- frame_ev_cnt  out  CNT_W  accepted event count of the frame being streamed, saturating.
- ev_drop_cnt  out  CNT_W  cumulative count of out-of-range events, saturating.

## Operation
- Storage:
  - Two banks, each DEPTH x PIX_W, each with two ports.
  - Port E (events) is routed to bank[bank_sel]. Port R (readout/clear) is routed to bank[~bank_sel].
  - Port R reads synchronously in read-first mode: a read and a zero-write to the same address in one cycle return the old data.
  - Both ports can never address the same bank, so there are no collisions.
- Event write:
  - An accepted event with ev_addr < DEPTH performs a masked write of 1 to bit ev_pol only. The other bit is untouched, so no read-modify-write is needed.
  - An event with ev_addr >= DEPTH is still accepted (ev_ready is not gated by it), but it is not written. It increments ev_drop_cnt.
  - ev_ready = init_done.
- FSM states: INIT, IDLE, STREAM.
  - INIT, entered on reset: port R and port E both write zero at address k, for k = 0..DEPTH-1 (one per cycle, both banks). Exits to IDLE after k = DEPTH-1; init_done rises on that edge.
  - IDLE: rd_start (sampled here only) toggles bank_sel, latches frame_ev_cnt, clears the event counter, resets the fetch pointer to 0, and moves to STREAM.
  - STREAM: one-entry output register.
    - A fetch occurs when the pointer is < DEPTH and (!rd_valid | rd_ready).
    - A fetch reads and zero-writes at the pointer, then increments it. rd_valid/rd_data/rd_addr update on the next edge.
    - Returns to IDLE on the edge where the beat with rd_last is accepted.
- rd_start in INIT or STREAM is ignored. It is not queued.
- Event counter:
  - Counts accepted in-range events and saturates at 2^CNT_W-1.
  - On the swap edge, frame_ev_cnt <= counter + (in-range event accepted that same cycle, saturating); the counter <= 0.
- Reset values:
  - ev_ready = 0, rd_busy = 0, rd_valid = 0, rd_last = 0, init_done = 0, bank_sel = 0.
  - rd_data = 0, rd_addr = 0, frame_ev_cnt = 0, ev_drop_cnt = 0.
  - Reset asserted mid-STREAM or mid-INIT aborts the operation immediately and restarts INIT on release.

## Timing
- Event latency: written on the acceptance edge; appears in the stream of the frame after the next swap.
- Swap boundary: rd_start high in IDLE at cycle T.
  - An event accepted in cycle T lands in the old bank and is counted in that frame.
  - Events from T+1 onward go to the new bank.
  - bank_sel and rd_busy change at the end of T.
- First beat: fetch in T+1, rd_valid high in T+2.
- Throughput: with rd_ready held high, one beat per cycle, so a frame takes DEPTH+1 cycles from rd_start to the last beat.
- Backpressure: while rd_valid & !rd_ready, rd_data, rd_addr and rd_last are held and no fetch occurs.
- rd_busy falls on the edge that accepts the rd_last beat. rd_start may be issued in the following cycle.
- INIT takes exactly DEPTH cycles after reset release.

## Test plan
- Reset then INIT, DEPTH=16: init_done and ev_ready rise 16 cycles after rst_n release. rd_start pulsed during INIT is ignored; rd_busy stays 0.
- Events: addr 3 pol 1, addr 3 pol 0, addr 7 pol 0, then rd_start with rd_ready=1.
  - 16 beats at addresses 0..15; addr 3 = 2'b11, addr 7 = 2'b01, all others 0.
  - rd_last on addr 15; frame_ev_cnt = 3.
- Clear-behind: issue two consecutive rd_start frames with no events between them. The second frame streams all zeros, and the first bank is also all zeros when it is streamed two swaps later.
- Swap boundary: an event at addr 5 in the rd_start cycle and an event at addr 6 in the next cycle. Addr 5 appears in the current stream; addr 6 appears only in the next frame.
- Backpressure: toggle rd_ready pseudo-randomly. The sink sees addresses 0..15 exactly once, in order, with data stable while stalled, and frame_ev_cnt unchanged throughout.
- Out-of-range and saturation:
  - addr 20 with DEPTH=16: ev_drop_cnt increments; no pixel changes.
  - CNT_W=4 with 20 in-range events: frame_ev_cnt = 15.
  - rst_n asserted mid-stream: all outputs return to their reset values, followed by a full INIT.
